// File: rtl/riscv_ctrl_pkg.sv
// Shared constants, state encoding and opcode decode helper for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

    localparam int unsigned OP_WIDTH      = 7;
    localparam int unsigned ALUCTRL_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_WIDTH-1:0] OP_LUI    = 7'b0110111;

    localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_PASSB = 3'b110;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StLui
    } state_e;

    // State that follows DECODE; StFetch means the instruction is unsupported.
    function automatic state_e decode_target(input logic [OP_WIDTH-1:0] op,
                                             input logic [2:0] funct3);
        case (op)
            OP_LOAD, OP_STORE: return StMemAdr;
            OP_RTYPE:          return (funct3 == 3'b000) ? StExecR : StFetch;
            OP_ITYPE:          return (funct3 == 3'b000) ? StExecI : StFetch;
            OP_BRANCH:         return (funct3[2:1] == 2'b00) ? StBranch : StFetch;
            OP_JAL:            return StJal;
            OP_LUI:            return StLui;
            default:           return StFetch;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle controller (master) and the shared datapath (slave).
interface multicycle_ctrl_fsm_if;
    import riscv_ctrl_pkg::*;

    logic [OP_WIDTH-1:0]      op;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic                     Zero;
    logic                     mem_ready;
    logic                     PCWrite;
    logic                     AdrSrc;
    logic                     MemWrite;
    logic                     IRWrite;
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [1:0]               ImmSrc;
    logic [ALUCTRL_WIDTH-1:0] ALUctrl;
    logic                     illegal_instr;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, illegal_instr
    );

endinterface

// File: rtl/imm_src_dec.sv
// Immediate-format select decoded straight from the opcode: 00 I, 01 S, 10 B, 11 J/U.
module imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    output logic [1:0]          imm_src
);

    always_comb begin
        case (op)
            OP_STORE:       imm_src = 2'b01;
            OP_BRANCH:      imm_src = 2'b10;
            OP_JAL, OP_LUI: imm_src = 2'b11;
            default:        imm_src = 2'b00;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, write strobes and the ALU operation code.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    state_e                   state;
    logic [1:0]               imm_src;
    logic                     pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]               result_src, alu_src_a, alu_src_b, imm_out;
    logic [ALUCTRL_WIDTH-1:0] alu_ctrl;

    imm_src_dec u_imm_src_dec (
        .op      (bus.op),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StFetch;
        end else begin
            case (state)
                StFetch:    if (bus.mem_ready) state <= StDecode;
                StDecode:   state <= decode_target(bus.op, bus.funct3);
                StMemAdr:   state <= (bus.op == OP_STORE) ? StMemWrite : StMemRead;
                StMemRead:  if (bus.mem_ready) state <= StMemWb;
                StMemWrite: if (bus.mem_ready) state <= StFetch;
                StExecR, StExecI, StJal, StLui: state <= StAluWb;
                default:    state <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        imm_out    = imm_src;
        case (state)
            StFetch: begin
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal   = (decode_target(bus.op, bus.funct3) == StFetch);
            end
            StMemAdr, StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead:  adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                if (bus.funct3 == 3'b000 && bus.funct7b5) alu_ctrl = ALU_SUB;
            end
            StAluWb:    reg_write = 1'b1;
            StBranch: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                if (bus.funct3 == 3'b000)      pc_write = bus.Zero;
                else if (bus.funct3 == 3'b001) pc_write = ~bus.Zero;
            end
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            StLui: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_PASSB;
            end
            default: ;
        endcase
        // Reset must silence every output at once, including the opcode-driven ImmSrc.
        if (!rst_n) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_ctrl   = '0;
            imm_out    = 2'b00;
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.AdrSrc        = adr_src;
    assign bus.MemWrite      = mem_write;
    assign bus.IRWrite       = ir_write;
    assign bus.RegWrite      = reg_write;
    assign bus.ResultSrc     = result_src;
    assign bus.ALUSrcA       = alu_src_a;
    assign bus.ALUSrcB       = alu_src_b;
    assign bus.ImmSrc        = imm_out;
    assign bus.ALUctrl       = alu_ctrl;
    assign bus.illegal_instr = illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench: each instruction class expands into its expected per-cycle output trace.
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {KLoad, KStore, KRType, KIType, KBranch, KJal, KLui, KIllegal} klass_e;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rw_seen;
    int         mw_seen;
    logic [1:0] cur_imm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {15'd0, bus.illegal_instr, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUctrl};
    endfunction

    function automatic logic [31:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ctl, input logic ill);
        return {15'd0, ill, pcw, adr, mw, irw, rw, rs, sa, sb, cur_imm, ctl};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 2'b01;
            7'b1100011:             return 2'b10;
            7'b1101111, 7'b0110111: return 2'b11;
            default:                return 2'b00;
        endcase
    endfunction

    function automatic klass_e classify(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b0000011) return KLoad;
        if (op == 7'b0100011) return KStore;
        if (op == 7'b0110011 && f3 == 3'd0) return KRType;
        if (op == 7'b0010011 && f3 == 3'd0) return KIType;
        if (op == 7'b1100011 && f3 <= 3'd1) return KBranch;
        if (op == 7'b1101111) return KJal;
        if (op == 7'b0110111) return KLui;
        return KIllegal;
    endfunction

    // Inputs are already set; sample mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check(tag, observed(), exp);
        rw_seen += int'(bus.RegWrite);
        mw_seen += int'(bus.MemWrite & bus.mem_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input string tag, input int stall, input logic [31:0] exp);
        for (int i = 0; i < stall; i++) begin
            bus.mem_ready = 1'b0;
            cyc({tag, "_wait"}, exp);
        end
        bus.mem_ready = 1'b1;
        cyc(tag, exp);
    endtask

    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fstall, input int mstall);
        klass_e k;
        logic   pcw;
        k = classify(op, f3);
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.Zero = z;
        cur_imm = exp_imm(op);
        rw_seen = 0;
        mw_seen = 0;
        for (int i = 0; i < fstall; i++) begin
            bus.mem_ready = 1'b0;
            cyc({nm, ".fetch_wait"}, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
        end
        bus.mem_ready = 1'b1;
        cyc({nm, ".fetch"}, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
        bus.mem_ready = 1'($urandom);
        cyc({nm, ".decode"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, k == KIllegal));
        bus.mem_ready = 1'($urandom);
        case (k)
            KLoad: begin
                cyc({nm, ".memadr"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
                mem_phase({nm, ".memread"}, mstall,
                          mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
                bus.mem_ready = 1'($urandom);
                cyc({nm, ".memwb"}, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0));
            end
            KStore: begin
                cyc({nm, ".memadr"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
                mem_phase({nm, ".memwrite"}, mstall,
                          mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            end
            KRType: begin
                cyc({nm, ".exec_r"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
                                        f7 ? 3'b001 : 3'b000, 0));
                cyc({nm, ".aluwb"}, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            end
            KIType: begin
                cyc({nm, ".exec_i"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
                cyc({nm, ".aluwb"}, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            end
            KBranch: begin
                pcw = (f3 == 3'd0) ? z : ~z;
                cyc({nm, ".branch"}, mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
            end
            KJal: begin
                cyc({nm, ".jal"}, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0));
                cyc({nm, ".aluwb"}, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            end
            KLui: begin
                cyc({nm, ".lui"}, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b110, 0));
                cyc({nm, ".aluwb"}, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            end
            default: ;
        endcase
        check({nm, ".regwrites"}, rw_seen,
              (k == KStore || k == KBranch || k == KIllegal) ? 32'd1 - 32'd1 : 32'd1);
        check({nm, ".memwrites"}, mw_seen, (k == KStore) ? 32'd1 : 32'd0);
    endtask

    task automatic run_word(input string nm, input logic [31:0] instr, input logic z,
                            input int fstall, input int mstall);
        run_instr(nm, instr[6:0], instr[14:12], instr[30], z, fstall, mstall);
    endtask

    logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b0110111};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        rst_n = 1'b0;
        bus.op = 7'b0110111;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b1;
        bus.mem_ready = 1'b1;
        #2 check("reset_outputs", observed(), 32'd0);
        @(negedge clk);
        check("reset_held", observed(), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_word("add", 32'h002081B3, 1'b0, 1, 0);
        run_word("sub", 32'h402081B3, 1'b1, 0, 0);

        // Abort an add in EXEC_R with an asynchronous reset.
        bus.op = 7'b0110011;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        cur_imm = 2'b00;
        bus.mem_ready = 1'b1;
        cyc("abort.fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
        cyc("abort.decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
        #2 rst_n = 1'b0;
        #1 check("reset_mid_exec", observed(), 32'd0);
        @(negedge clk);
        check("reset_mid_exec_held", observed(), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        cyc("post_reset_fetch", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

        run_word("lw", 32'h0020A183, 1'b0, 0, 2);
        run_word("sw", 32'h0030A023, 1'b0, 1, 3);
        run_word("addi", 32'h00108093, 1'b0, 0, 0);
        run_word("beq_taken", 32'h00208463, 1'b1, 0, 0);
        run_word("beq_not", 32'h00208463, 1'b0, 0, 0);
        run_word("bne_taken", 32'h00209463, 1'b0, 0, 0);
        run_word("bne_not", 32'h00209463, 1'b1, 0, 0);
        run_word("lui", 32'h000011B7, 1'b0, 0, 0);
        run_word("jal", 32'h008000EF, 1'b0, 2, 0);
        run_word("illegal_op", 32'h0000007F, 1'b0, 0, 0);
        run_word("illegal_sll", 32'h002091B3, 1'b0, 0, 0);
        run_word("illegal_blt", 32'h0020C463, 1'b1, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 6)];
            else op = 7'($urandom);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (op == 7'b1100011) f3 = 3'($urandom_range(0, 1));
            else f3 = 3'd0;
            run_instr("rand", op, f3, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
